tick_period_meter: RTL and testbench

Measures the interval, in `clk` cycles, between successive single-cycle tick pulses and reports it with a validity strobe, a lock flag and a timeout flag. It sits in the timing module on the receiving side of the tick interface, downstream of the frequency divider's tick output. It checks the beat rate the divider actually produces and tells the game logic when the rhythm is stable.

---
 rtl/tick_period_meter_pkg.sv | 7 +
 rtl/tick_period_meter_compare.sv | 16 +
 rtl/tick_period_meter.sv | 125 ++++++++++++
 tb/tb_tick_period_meter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/tick_period_meter_pkg.sv
// timing_pkg: shared state encoding and default parameters for the tick period meter.
package timing_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_FIRST, MEASURE, TIMEOUT} tpm_state_t;
    localparam int TPM_CNT_W  = 8;
    localparam int TPM_TOL    = 0;
    localparam int TPM_LOCK_N = 3;
endpackage

// File: rtl/tick_period_meter_compare.sv
// period_compare: flags two periods as matching when they differ by at most TOL cycles.
module period_compare #(
    parameter int W   = 8,
    parameter int TOL = 0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         match
);
    logic [W:0] diff;
    logic [W:0] mag;
    // One extra bit keeps the sign, so the magnitude never wraps.
    assign diff  = {1'b0, a} - {1'b0, b};
    assign mag   = diff[W] ? (~diff + 1'b1) : diff;
    assign match = 32'(mag) <= 32'(TOL);
endmodule

// File: rtl/tick_period_meter.sv
// tick_period_meter: measures cycles between tick pulses, reports them with a strobe,
// and tracks lock on a stable rhythm and timeout when ticks stop.
module tick_period_meter
    import timing_pkg::*;
#(
    parameter int CNT_W  = TPM_CNT_W,
    parameter int TOL    = TPM_TOL,
    parameter int LOCK_N = TPM_LOCK_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             tick_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);
    localparam logic [CNT_W-1:0] MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [3:0]       LOCK_V  = 4'(LOCK_N);

    tpm_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] prev_q, prev_d;
    logic [3:0]       match_q, match_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic             have_prev_q, have_prev_d;
    logic             same;
    logic [3:0]       match_upd;

    period_compare #(.W(CNT_W), .TOL(TOL)) u_cmp (
        .a     (cnt_q),
        .b     (prev_q),
        .match (same)
    );

    assign match_upd = !same ? 4'd0 : (match_q == LOCK_V) ? LOCK_V : match_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        period_d    = period_q;
        prev_d      = prev_q;
        match_d     = match_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        timeout_d   = timeout_q;
        have_prev_d = have_prev_q;
        if (!enable) begin
            state_d     = IDLE;
            cnt_d       = '0;
            match_d     = '0;
            locked_d    = 1'b0;
            timeout_d   = 1'b0;
            have_prev_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = WAIT_FIRST;
                // A tick here only arms the counter; there is no earlier tick to measure from.
                WAIT_FIRST, TIMEOUT: begin
                    have_prev_d = 1'b0;
                    if (tick_in) begin
                        state_d   = MEASURE;
                        cnt_d     = CNT_ONE;
                        timeout_d = 1'b0;
                    end
                end
                MEASURE: begin
                    if (tick_in) begin
                        period_d    = cnt_q;
                        valid_d     = 1'b1;
                        cnt_d       = CNT_ONE;
                        prev_d      = cnt_q;
                        have_prev_d = 1'b1;
                        if (have_prev_q) begin
                            match_d  = match_upd;
                            locked_d = match_upd == LOCK_V;
                        end
                    end else if (cnt_q == MAX) begin
                        state_d   = TIMEOUT;
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        match_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            period_q    <= '0;
            prev_q      <= '0;
            match_q     <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
            have_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            prev_q      <= prev_d;
            match_q     <= match_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign period_out   = period_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;
endmodule

// File: tb/tb_tick_period_meter.sv
// tb_tick_period_meter: three meters (8b/TOL0, 8b/TOL2, 4b/TOL0) share one stimulus
// stream and are checked every cycle against a tick-timestamp model.
module tb_tick_period_meter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       tk  = 1'b0;
    logic [7:0] p0, p1;
    logic [3:0] p2;
    logic [2:0] v, l, to;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;
    int k      = 0;

    int mx[3]  = '{255, 255, 15};
    int tol[3] = '{0, 2, 0};
    int m_po[3], m_prev[3], m_mc[3], m_tl[3];
    bit m_pv[3], m_lk[3], m_to[3], m_idle[3], m_arm[3], m_hp[3];

    always #5 clk = ~clk;

    tick_period_meter #(.CNT_W(8), .TOL(0), .LOCK_N(3)) d0 (
        .clk(clk), .rst(rst), .enable(en), .tick_in(tk),
        .period_out(p0), .period_valid(v[0]), .locked(l[0]), .timeout(to[0]));
    tick_period_meter #(.CNT_W(8), .TOL(2), .LOCK_N(3)) d1 (
        .clk(clk), .rst(rst), .enable(en), .tick_in(tk),
        .period_out(p1), .period_valid(v[1]), .locked(l[1]), .timeout(to[1]));
    tick_period_meter #(.CNT_W(4), .TOL(0), .LOCK_N(3)) d2 (
        .clk(clk), .rst(rst), .enable(en), .tick_in(tk),
        .period_out(p2), .period_valid(v[2]), .locked(l[2]), .timeout(to[2]));

    function automatic int dper(int i);
        return i == 0 ? int'(p0) : i == 1 ? int'(p1) : int'(p2);
    endfunction

    task automatic chk(string n, int i, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s d%0d got %0d expected %0d at %0t", n, i, got, exp, $time);
        end
    endtask

    // Model works from tick timestamps: a period is the edge-index gap between ticks.
    task automatic model(bit r, bit e, bit t);
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                m_idle[i] = 1; m_arm[i] = 0; m_to[i] = 0; m_lk[i] = 0; m_mc[i] = 0;
                m_po[i] = 0; m_pv[i] = 0; m_prev[i] = 0; m_hp[i] = 0;
            end else if (!e) begin
                m_idle[i] = 1; m_arm[i] = 0; m_to[i] = 0; m_lk[i] = 0; m_mc[i] = 0;
                m_pv[i] = 0; m_hp[i] = 0;
            end else if (m_idle[i]) begin
                m_idle[i] = 0; m_pv[i] = 0;
            end else if (!m_arm[i]) begin
                m_pv[i] = 0; m_hp[i] = 0;
                if (t) begin m_arm[i] = 1; m_tl[i] = k; m_to[i] = 0; end
            end else if (t) begin
                int p, d;
                p = k - m_tl[i];
                m_tl[i] = k; m_pv[i] = 1; m_po[i] = p;
                if (m_hp[i]) begin
                    d = p - m_prev[i];
                    if (d < 0) d = -d;
                    m_mc[i] = (d <= tol[i]) ? ((m_mc[i] + 1 > 3) ? 3 : m_mc[i] + 1) : 0;
                    m_lk[i] = (m_mc[i] == 3);
                end
                m_prev[i] = p; m_hp[i] = 1;
            end else begin
                m_pv[i] = 0;
                if (k - m_tl[i] == mx[i]) begin
                    m_arm[i] = 0; m_to[i] = 1; m_lk[i] = 0; m_mc[i] = 0;
                end
            end
        end
        k++;
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_on)
            for (int i = 0; i < 3; i++) begin
                chk("period", i, dper(i), m_po[i]);
                chk("valid", i, int'(v[i]), int'(m_pv[i]));
                chk("locked", i, int'(l[i]), int'(m_lk[i]));
                chk("timeout", i, int'(to[i]), int'(m_to[i]));
            end
    end

    task automatic step(bit r, bit e, bit t);
        @(negedge clk);
        rst = r; en = e; tk = t;
        model(r, e, t);
        @(posedge clk);
        #2;
    endtask

    task automatic gap(int g);
        repeat (g - 1) step(0, 1, 0);
        step(0, 1, 1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) m_idle[i] = 1;
        chk_on = 1;
        step(1, 0, 0);
        step(1, 0, 0);
        chk("lit_rst_period", 0, int'(p0), 0);
        chk("lit_rst_valid", 0, int'(v[0]), 0);
        step(0, 1, 0);
        step(0, 1, 1);
        chk("lit_arm_nostrobe", 0, int'(v[0]), 0);
        gap(5); gap(5); gap(5);
        chk("lit_3rd_unlocked", 0, int'(l[0]), 0);
        gap(5);
        chk("lit_4th_locked", 0, int'(l[0]), 1);
        chk("lit_4th_period", 0, int'(p0), 5);
        chk("lit_4th_valid", 0, int'(v[0]), 1);
        gap(5);
        gap(7);
        chk("lit_slip_period", 0, int'(p0), 7);
        chk("lit_slip_unlock", 0, int'(l[0]), 0);
        chk("lit_slip_tol2", 1, int'(l[1]), 1);
        gap(5); gap(5); gap(5);
        chk("lit_relock_pending", 0, int'(l[0]), 0);
        gap(5);
        chk("lit_relocked", 0, int'(l[0]), 1);
        repeat (4) step(0, 1, 0);
        step(0, 0, 1);
        chk("lit_dis_nostrobe", 0, int'(v[0]), 0);
        chk("lit_dis_unlock", 0, int'(l[0]), 0);
        chk("lit_dis_hold", 0, int'(p0), 5);
        step(0, 1, 0);
        step(0, 1, 1);
        chk("lit_reen_arm", 0, int'(v[0]), 0);
        gap(4);
        chk("lit_reen_period", 0, int'(p0), 4);
        repeat (14) step(0, 1, 0);
        chk("lit_to_before", 2, int'(to[2]), 0);
        step(0, 1, 0);
        chk("lit_to_set", 2, int'(to[2]), 1);
        chk("lit_to_unlocked", 2, int'(l[2]), 0);
        step(0, 1, 1);
        chk("lit_to_clear", 2, int'(to[2]), 0);
        chk("lit_to_nostrobe", 2, int'(v[2]), 0);
        chk("lit_long_period", 0, int'(p0), 16);
        gap(3);
        chk("lit_after_to", 2, int'(p2), 3);
        gap(15);
        chk("lit_max_period", 2, int'(p2), 15);
        chk("lit_max_valid", 2, int'(v[2]), 1);
        chk("lit_max_noto", 2, int'(to[2]), 0);
        gap(16);
        step(0, 1, 1);
        chk("lit_b2b_first", 0, int'(v[0]), 1);
        step(0, 1, 1);
        chk("lit_b2b_valid", 0, int'(v[0]), 1);
        chk("lit_b2b_period", 0, int'(p0), 1);
        step(0, 1, 0);
        step(0, 1, 0);
        step(1, 1, 0);
        chk("lit_mid_rst_period", 0, int'(p0), 0);
        chk("lit_mid_rst_to", 2, int'(to[2]), 0);
        step(0, 1, 1);
        step(0, 1, 1);
        chk("lit_post_rst_arm", 0, int'(v[0]), 0);
        gap(3);
        chk("lit_post_rst_period", 0, int'(p0), 3);
        step(0, 1, 0);
        chk_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
